// File: rtl/s2mm_frame_packer_if.sv
// AXI-Stream beat interface between the frame packer and the DMA S2MM sink.
interface s2mm_frame_packer_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/s2mm_frame_packer.sv
// Packs 16-bit samples into 32-bit beats, buffers them in a FWFT FIFO and
// frames them with tlast every frame_beats beats; counts samples dropped on back-pressure.
module s2mm_frame_packer #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic [CNT_W-1:0]       frame_beats_i,
  input  logic [SAMPLE_W-1:0]    sample_in_i,
  input  logic                   sample_vld_i,
  s2mm_frame_packer_if.master    m_axis,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  localparam int unsigned BEAT_W = 2 * SAMPLE_W;
  localparam int unsigned KEEP_W = BEAT_W / 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [KEEP_W-1:0] KEEP_HALF = {{(KEEP_W/2){1'b0}}, {(KEEP_W/2){1'b1}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    frame_last_q, frame_last_d;
  logic                pair_vld_q, pair_vld_d;
  logic [SAMPLE_W-1:0] pair_lo_q, pair_lo_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;

  logic [BEAT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] half_q;

  logic              wr_en;
  logic              wr_half;
  logic [BEAT_W-1:0] wr_data;
  logic              fifo_full;
  logic              head_vld;
  logic              head_last;
  logic              rd_en;

  // Full is judged on the registered occupancy, so a same-cycle read never frees a slot.
  assign fifo_full = (occ_q == OCC_FULL);
  assign head_vld  = (occ_q != '0);
  assign head_last = (beat_cnt_q == frame_last_q) ||
                     ((state_q == ST_FLUSH) && (occ_q == OCC_W'(1)) && !pair_vld_q);
  assign rd_en     = head_vld && m_axis.tready;

  always_comb begin
    state_d      = state_q;
    frame_last_d = frame_last_q;
    pair_vld_d   = pair_vld_q;
    pair_lo_d    = pair_lo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    beat_cnt_d   = beat_cnt_q;
    drop_d       = drop_q;
    ovf_d        = ovf_q;
    wr_en        = 1'b0;
    wr_half      = 1'b0;
    wr_data      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          frame_last_d = (frame_beats_i == '0) ? '0 : frame_beats_i - CNT_W'(1);
          drop_d       = '0;
          ovf_d        = 1'b0;
          beat_cnt_d   = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sample_vld_i) begin
          if (!pair_vld_q) begin
            pair_lo_d  = sample_in_i;
            pair_vld_d = 1'b1;
          end else begin
            pair_vld_d = 1'b0;
            if (!fifo_full) begin
              wr_en   = 1'b1;
              wr_data = {sample_in_i, pair_lo_q};
            end else begin
              // Whole pair is discarded so low/high sample alignment is preserved.
              drop_d = (drop_q > CNT_MAX - CNT_W'(2)) ? CNT_MAX : drop_q + CNT_W'(2);
              ovf_d  = 1'b1;
            end
          end
        end
        if (!enable_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pair_vld_q && !fifo_full) begin
          wr_en      = 1'b1;
          wr_half    = 1'b1;
          wr_data    = {SAMPLE_W'(0), pair_lo_q};
          pair_vld_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      beat_cnt_d = head_last ? '0 : beat_cnt_q + CNT_W'(1);
    end

    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if ((state_q == ST_FLUSH) && !pair_vld_d && (occ_d == '0)) state_d = ST_IDLE;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_last_q <= '0;
      pair_vld_q   <= 1'b0;
      pair_lo_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      beat_cnt_q   <= '0;
      drop_q       <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_last_q <= frame_last_d;
      pair_vld_q   <= pair_vld_d;
      pair_lo_q    <= pair_lo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      beat_cnt_q   <= beat_cnt_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
    end
  end

  // Beat storage; contents are don't-care while the occupancy marks them empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q]  <= wr_data;
      half_q[wr_ptr_q] <= wr_half;
    end
  end

  assign m_axis.tvalid = head_vld;
  assign m_axis.tdata  = head_vld ? mem_q[rd_ptr_q] : '0;
  assign m_axis.tkeep  = head_vld ? (half_q[rd_ptr_q] ? KEEP_HALF : '1) : '0;
  assign m_axis.tlast  = head_vld && head_last;
  assign drop_cnt_o    = drop_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_s2mm_frame_packer.sv
// Scoreboard bench for s2mm_frame_packer: a cycle model pushes expected beats,
// a monitor pops and compares them on every handshake.
module tb_s2mm_frame_packer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] frame_beats;
  logic [15:0] sample_in;
  logic        sample_vld;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        busy;

  s2mm_frame_packer_if #(.DATA_W(32)) axis_if ();

  s2mm_frame_packer #(.SAMPLE_W(16), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .frame_beats_i (frame_beats),
    .sample_in_i   (sample_in),
    .sample_vld_i  (sample_vld),
    .m_axis        (axis_if),
    .drop_cnt_o    (drop_cnt),
    .overflow_o    (overflow),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;
  beat_t exp_q[$];

  // model state
  int          m_state, m_count, m_idx, m_frame, m_drop;
  logic        m_half;
  logic [15:0] m_lo;

  // monitor state
  int          n_out, gen, tl_gen, tl_first_n, base_out;
  logic        stalled;
  logic [31:0] st_d, last_d;
  logic [3:0]  st_k, last_k;
  logic        st_l, last_l;

  task automatic model_step();
    bit    hs, w, to_flush;
    int    prev;
    beat_t b;
    hs = (m_count > 0) && (axis_if.tready === 1'b1);
    w = 0; to_flush = 0; prev = m_state;
    case (m_state)
      0: if (enable) begin
        m_state = 1;
        m_frame = (frame_beats == 16'd0) ? 1 : int'(frame_beats);
        m_idx = 0; m_drop = 0;
      end
      1: begin
        if (sample_vld) begin
          if (!m_half) begin
            m_lo = sample_in; m_half = 1'b1;
          end else begin
            m_half = 1'b0;
            if (m_count < DEPTH) begin
              b.d = {sample_in, m_lo}; b.k = 4'hF; b.l = ((m_idx % m_frame) == m_frame - 1);
              m_idx++; exp_q.push_back(b); w = 1;
            end else begin
              m_drop = (m_drop >= 65534) ? 65535 : m_drop + 2;
            end
          end
        end
        if (!enable) begin m_state = 2; to_flush = 1; end
      end
      default: begin
        if (m_half && m_count < DEPTH) begin
          b.d = {16'h0000, m_lo}; b.k = 4'h3; b.l = 1'b1;
          exp_q.push_back(b); m_half = 1'b0; w = 1;
        end
      end
    endcase
    m_count = m_count + int'(w) - int'(hs);
    if (to_flush && !m_half && m_count > 0 && exp_q.size() > 0) begin
      b = exp_q.pop_back(); b.l = 1'b1; exp_q.push_back(b);
    end
    if (prev == 2 && !m_half && m_count == 0) m_state = 0;
  endtask

  task automatic mon_step();
    beat_t e;
    if (stalled) begin
      checks++;
      if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== st_d || axis_if.tkeep !== st_k || axis_if.tlast !== st_l) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                 axis_if.tvalid, axis_if.tdata, axis_if.tkeep, axis_if.tlast, st_d, st_k, st_l);
      end
    end
    stalled = 1'b0;
    if (axis_if.tvalid === 1'b1) begin
      if (axis_if.tready === 1'b1) begin
        n_out++;
        last_d = axis_if.tdata; last_k = axis_if.tkeep; last_l = axis_if.tlast;
        if (axis_if.tlast === 1'b1 && tl_gen != gen) begin tl_gen = gen; tl_first_n = n_out; end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h k=%h l=%b want no beat", axis_if.tdata, axis_if.tkeep, axis_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if (axis_if.tdata !== e.d || axis_if.tkeep !== e.k || axis_if.tlast !== e.l) begin
            errors++;
            $display("FAIL beat %0d: got d=%h k=%h l=%b want d=%h k=%h l=%b",
                     n_out, axis_if.tdata, axis_if.tkeep, axis_if.tlast, e.d, e.k, e.l);
          end
        end
      end else begin
        stalled = 1'b1; st_d = axis_if.tdata; st_k = axis_if.tkeep; st_l = axis_if.tlast;
      end
    end
  endtask

  task automatic scoreboard();
    forever begin
      @(posedge clk or negedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_state = 0; m_count = 0; m_half = 1'b0; m_drop = 0; m_idx = 0;
        exp_q.delete(); stalled = 1'b0;
      end else if (clk === 1'b1) begin
        model_step();
      end else begin
        mon_step();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [15:0] fb);
    frame_beats = fb; enable = 1'b1; sample_vld = 1'b0; axis_if.tready = 1'b1;
    gen++; base_out = n_out;
    tick();
  endtask

  task automatic send(input logic [15:0] v);
    sample_in = v; sample_vld = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      tick();
      if (busy === 1'b0) break;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout: got busy=%b want 0", busy); end
  endtask

  task automatic finish_run();
    sample_vld = 1'b0; axis_if.tready = 1'b1; enable = 1'b0;
    wait_idle();
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_leftover: got %0d beats want 0", name, exp_q.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", axis_if.tvalid); end
    checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", axis_if.tlast); end
    checks++; if (axis_if.tkeep !== 4'h0) begin errors++; $display("FAIL rst_tkeep: got %h want 0", axis_if.tkeep); end
    checks++; if (axis_if.tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0", axis_if.tdata); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rst_drop: got %h want 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_basic();
    start(16'd4);
    send(16'h0001);
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %b want 0", axis_if.tvalid); end
    send(16'h0002);
    checks++; if (axis_if.tvalid !== 1'b1) begin errors++; $display("FAIL first_valid_latency: got %b want 1", axis_if.tvalid); end
    checks++; if (axis_if.tdata !== 32'h00020001) begin errors++; $display("FAIL first_beat_data: got %h want 00020001", axis_if.tdata); end
    for (int i = 3; i <= 16; i++) send(16'(i));
    finish_run();
    checks++; if (n_out - base_out != 8) begin errors++; $display("FAIL basic_count: got %0d want 8", n_out - base_out); end
    checks++; if (tl_gen != gen || tl_first_n - base_out != 4) begin errors++; $display("FAIL basic_first_tlast: got %0d want 4", tl_first_n - base_out); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL basic_drop: got %h want 0", drop_cnt); end
    check_drained("basic");
  endtask

  task automatic test_overflow();
    start(16'd4);
    axis_if.tready = 1'b0;
    for (int i = 1; i <= 40; i++) send(16'(i));
    sample_vld = 1'b0; tick();
    checks++; if (drop_cnt !== 16'd8) begin errors++; $display("FAIL ovf_drop: got %0d want 8", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (axis_if.tdata !== 32'h00020001) begin errors++; $display("FAIL ovf_head: got %h want 00020001", axis_if.tdata); end
    finish_run();
    checks++; if (n_out - base_out != 16) begin errors++; $display("FAIL ovf_count: got %0d want 16", n_out - base_out); end
    checks++; if (drop_cnt !== 16'd8) begin errors++; $display("FAIL ovf_drop_hold: got %0d want 8", drop_cnt); end
    check_drained("ovf");
  endtask

  task automatic test_flush();
    start(16'd4);
    for (int i = 1; i <= 4; i++) send(16'(i));
    sample_in = 16'h0005; sample_vld = 1'b1; enable = 1'b0;
    tick();
    sample_vld = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b want 1", busy); end
    wait_idle();
    checks++; if (n_out - base_out != 3) begin errors++; $display("FAIL flush_count: got %0d want 3", n_out - base_out); end
    checks++; if (last_d !== 32'h00000005 || last_k !== 4'h3 || last_l !== 1'b1) begin
      errors++; $display("FAIL flush_last_beat: got d=%h k=%h l=%b want d=00000005 k=3 l=1", last_d, last_k, last_l);
    end
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid: got %b want 0", axis_if.tvalid); end
    check_drained("flush");
  endtask

  task automatic test_random();
    logic [15:0] v;
    int cnt;
    start(16'd4);
    v = 16'h0001; cnt = 0;
    while (cnt < 1000) begin
      axis_if.tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0) begin
        sample_in = v; sample_vld = 1'b1; v++; cnt++;
      end else begin
        sample_vld = 1'b0;
      end
      tick();
    end
    finish_run();
    check_drained("rand");
    checks++; if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rand_drop: got %0d want %0d", drop_cnt, m_drop); end
    checks++; if (2 * (n_out - base_out) + int'(drop_cnt) != 1000) begin
      errors++; $display("FAIL rand_accounting: got %0d want 1000", 2 * (n_out - base_out) + int'(drop_cnt));
    end
    checks++; if (overflow !== (m_drop != 0)) begin errors++; $display("FAIL rand_overflow: got %b want %b", overflow, m_drop != 0); end
  endtask

  task automatic test_reset_mid();
    start(16'd4);
    axis_if.tready = 1'b0;
    for (int i = 1; i <= 6; i++) send(16'(i));
    sample_vld = 1'b0; tick();
    checks++; if (axis_if.tvalid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b want 1", axis_if.tvalid); end
    rst_n = 1'b0; #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b want 0", axis_if.tvalid); end
    checks++; if (drop_cnt !== 16'h0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_cnt: got %h/%b want 0/0", drop_cnt, overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    enable = 1'b0; axis_if.tready = 1'b1;
    tick(); tick();
    rst_n = 1'b1; tick();
    start(16'd4);
    for (int i = 16'h0101; i <= 16'h0108; i++) send(16'(i));
    finish_run();
    checks++; if (n_out - base_out != 4) begin errors++; $display("FAIL mid_count: got %0d want 4", n_out - base_out); end
    checks++; if (tl_gen != gen || tl_first_n - base_out != 4) begin errors++; $display("FAIL mid_first_tlast: got %0d want 4", tl_first_n - base_out); end
    check_drained("mid");
  endtask

  task automatic test_frame0();
    start(16'd0);
    for (int i = 1; i <= 8; i++) send(16'(16'h0200 + i));
    finish_run();
    checks++; if (n_out - base_out != 4) begin errors++; $display("FAIL f0_count: got %0d want 4", n_out - base_out); end
    checks++; if (tl_gen != gen || tl_first_n - base_out != 1) begin errors++; $display("FAIL f0_first_tlast: got %0d want 1", tl_first_n - base_out); end
    check_drained("f0");
  endtask

  initial begin
    checks = 0; errors = 0; n_out = 0; gen = 0; tl_gen = 0; tl_first_n = 0; base_out = 0;
    stalled = 1'b0; m_state = 0; m_count = 0; m_half = 1'b0; m_drop = 0; m_idx = 0; m_frame = 1;
    rst_n = 1'b0; enable = 1'b0; frame_beats = 16'd4; sample_in = '0; sample_vld = 1'b0;
    axis_if.tready = 1'b1;
    fork scoreboard(); join_none
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_random();
    test_reset_mid();
    test_frame0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
